// File: rtl/fpu_addsub_arbiter.sv
// Shares one pipelined FP add/sub unit between NUM_REQ requesters, with an ID tag pipeline steering results back.
// Define FPU_ARB_FIXED_PRI_EN for fixed lowest-index-wins priority; the default build is round-robin.
module fpu_addsub_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int LAT     = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [NUM_REQ*32-1:0] req_opa,
  input  logic [NUM_REQ*32-1:0] req_opb,
  input  logic [NUM_REQ-1:0]    req_add,
  output logic [31:0]           fpu_opa,
  output logic [31:0]           fpu_opb,
  output logic                  fpu_add,
  output logic                  fpu_issue,
  input  logic [31:0]           fpu_result,
  output logic [NUM_REQ-1:0]    rsp_valid,
  output logic [NUM_REQ*32-1:0] rsp_data,
  input  logic [NUM_REQ-1:0]    rsp_ready
);
  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]    busy_q, busy_d;
  logic [NUM_REQ-1:0]    elig;
  logic                  grant_vld;
  logic [ID_W-1:0]       grant_id;
  logic [31:0]           fpu_opa_q, fpu_opa_d;
  logic [31:0]           fpu_opb_q, fpu_opb_d;
  logic                  fpu_add_q, fpu_add_d;
  logic                  fpu_issue_q, fpu_issue_d;
  logic [ID_W-1:0]       issue_id_q, issue_id_d;
  logic                  tag_vld_q [LAT];
  logic                  tag_vld_d [LAT];
  logic [ID_W-1:0]       tag_id_q  [LAT];
  logic [ID_W-1:0]       tag_id_d  [LAT];
  logic [NUM_REQ-1:0]    rsp_valid_q, rsp_valid_d;
  logic [NUM_REQ*32-1:0] rsp_data_q, rsp_data_d;

  assign elig      = req_valid & ~busy_q;
  assign grant_vld = |elig;

`ifdef FPU_ARB_FIXED_PRI_EN
  always_comb begin
    grant_id = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--)
      if (elig[k]) grant_id = ID_W'(k);
  end
`else
  logic [ID_W-1:0]      ptr_q, ptr_d;
  logic [2*NUM_REQ-1:0] elig_rot;
  logic [ID_W:0]        rr_sum;

  // Rotate eligibility so bit 0 is the requester at ptr; the lowest set bit of the rotation wins.
  always_comb begin
    elig_rot = {elig, elig} >> ptr_q;
    rr_sum   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--)
      if (elig_rot[k]) rr_sum = {1'b0, ptr_q} + (ID_W+1)'(k);
    grant_id = (rr_sum >= (ID_W+1)'(NUM_REQ)) ? ID_W'(rr_sum - (ID_W+1)'(NUM_REQ))
                                              : ID_W'(rr_sum);
    ptr_d = ptr_q;
    if (grant_vld)
      ptr_d = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end
`endif

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++)
      req_ready[i] = grant_vld && (grant_id == ID_W'(i));
  end

  // NOTE: every variable gets a default before any conditional update, so no latch is inferred.
  always_comb begin
    fpu_opa_d   = fpu_opa_q;
    fpu_opb_d   = fpu_opb_q;
    fpu_add_d   = fpu_add_q;
    fpu_issue_d = grant_vld;
    issue_id_d  = issue_id_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_ready[i]) begin
        fpu_opa_d  = req_opa[32*i +: 32];
        fpu_opb_d  = req_opb[32*i +: 32];
        fpu_add_d  = req_add[i];
        issue_id_d = ID_W'(i);
      end
    end

    // The last tag stage lines up with fpu_result.
    tag_vld_d[0] = fpu_issue_q;
    tag_id_d[0]  = issue_id_q;
    for (int s = 1; s < LAT; s++) begin
      tag_vld_d[s] = tag_vld_q[s-1];
      tag_id_d[s]  = tag_id_q[s-1];
    end

    busy_d      = (busy_q | (req_valid & req_ready)) & ~(rsp_valid_q & rsp_ready);
    rsp_valid_d = rsp_valid_q & ~rsp_ready;
    rsp_data_d  = rsp_data_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (tag_vld_q[LAT-1] && (tag_id_q[LAT-1] == ID_W'(i))) begin
        rsp_valid_d[i]         = 1'b1;
        rsp_data_d[32*i +: 32] = fpu_result;
      end
    end
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_q      <= '0;
      fpu_opa_q   <= '0;
      fpu_opb_q   <= '0;
      fpu_add_q   <= 1'b0;
      fpu_issue_q <= 1'b0;
      issue_id_q  <= '0;
      rsp_valid_q <= '0;
      // NOTE: result registers are visible on ports, so they are reset, unlike a plain data buffer.
      rsp_data_q  <= '0;
      for (int s = 0; s < LAT; s++) begin
        tag_vld_q[s] <= 1'b0;
        tag_id_q[s]  <= '0;
      end
    end else begin
      busy_q      <= busy_d;
      fpu_opa_q   <= fpu_opa_d;
      fpu_opb_q   <= fpu_opb_d;
      fpu_add_q   <= fpu_add_d;
      fpu_issue_q <= fpu_issue_d;
      issue_id_q  <= issue_id_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      tag_vld_q   <= tag_vld_d;
      tag_id_q    <= tag_id_d;
    end
  end

  assign fpu_opa   = fpu_opa_q;
  assign fpu_opb   = fpu_opb_q;
  assign fpu_add   = fpu_add_q;
  assign fpu_issue = fpu_issue_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
endmodule

// File: tb/tb_fpu_addsub_arbiter.sv
// Scoreboard bench for fpu_addsub_arbiter: random traffic, directed cases, a stub adder and a reference arbiter.
module tb_fpu_addsub_arbiter;
  localparam int N   = 4;
  localparam int LAT = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_ready;
  logic [N*32-1:0] req_opa = '0;
  logic [N*32-1:0] req_opb = '0;
  logic [N-1:0]    req_add = '0;
  logic [31:0]     fpu_opa, fpu_opb, fpu_result;
  logic            fpu_add, fpu_issue;
  logic [N-1:0]    rsp_valid;
  logic [N*32-1:0] rsp_data;
  logic [N-1:0]    rsp_ready = '0;

  fpu_addsub_arbiter #(.NUM_REQ(N), .LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_opa(req_opa), .req_opb(req_opb), .req_add(req_add),
    .fpu_opa(fpu_opa), .fpu_opb(fpu_opb), .fpu_add(fpu_add), .fpu_issue(fpu_issue),
    .fpu_result(fpu_result),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_ready(rsp_ready)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  always @(negedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cycle %0d: got %h, required %h", name, cyc, act, exp);
    end
  endtask

  // Float32 <-> real conversion for normal numbers; enough for a stub adder.
  function automatic real f2r(input logic [31:0] f);
    logic [63:0] d;
    if (f[30:23] == 8'd0) return 0.0;
    d = {f[31], 11'(f[30:23]) + 11'd896, f[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    d = $realtobits(r);
    if (d[62:0] == 63'd0) return 32'd0;
    return {d[63], 8'(int'(d[62:52]) - 896), d[51:29]};
  endfunction

  function automatic logic [31:0] addf(input logic [31:0] a, input logic [31:0] b, input logic add);
    return r2f(add ? f2r(a) + f2r(b) : f2r(a) - f2r(b));
  endfunction

  function automatic logic [31:0] rand_f();
    return {1'($urandom_range(0, 1)), 8'($urandom_range(120, 134)), 23'($urandom)};
  endfunction

  // Stub adder: result appears LAT cycles after the issue cycle; idle slots carry garbage.
  logic [31:0] pipe [LAT];
  always @(posedge clk) begin
    pipe[0] <= fpu_issue ? addf(fpu_opa, fpu_opb, fpu_add) : $urandom;
    for (int s = 1; s < LAT; s++) pipe[s] <= pipe[s-1];
  end
  assign fpu_result = pipe[LAT-1];

  // Reference model state.
  typedef struct { logic [31:0] data; int due; } exp_t;
  exp_t        exp_q [N][$];
  logic [N-1:0] m_busy = '0;
  int          m_ptr = 0;
  logic        m_iss = 1'b0;
  logic [31:0] m_opa, m_opb;
  logic        m_add;
  logic [N-1:0] fresh = '1;
  logic [31:0] pend_exp [N];
  int          gcnt [N];

  task automatic check_arb();
    logic [N-1:0] elig, exp_rdy;
    int g;
    elig = req_valid & ~m_busy;
    g = -1;
`ifdef FPU_ARB_FIXED_PRI_EN
    for (int k = N - 1; k >= 0; k--) if (elig[k]) g = k;
`else
    for (int k = N - 1; k >= 0; k--) if (elig[(m_ptr + k) % N]) g = (m_ptr + k) % N;
`endif
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    check("req_ready", 32'(req_ready), 32'(exp_rdy));
    check("fpu_issue", 32'(fpu_issue), 32'(m_iss));
    if (m_iss) begin
      check("fpu_opa", fpu_opa, m_opa);
      check("fpu_opb", fpu_opb, m_opb);
      check("fpu_add", 32'(fpu_add), 32'(m_add));
    end
    m_iss = (g >= 0);
    if (g >= 0) begin
      m_opa = req_opa[32*g +: 32];
      m_opb = req_opb[32*g +: 32];
      m_add = req_add[g];
      exp_q[g].push_back('{data: pend_exp[g], due: cyc + LAT + 2});
      m_busy[g] = 1'b1;
      m_ptr     = (g + 1) % N;
      fresh[g]  = 1'b1;
      gcnt[g]++;
    end
  endtask

  task automatic step(input logic [N-1:0] want_v, input logic [N-1:0] want_r);
    logic [31:0] a, b;
    logic ad;
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      if (want_v[i]) begin
        if (fresh[i]) begin
          a = rand_f();
          b = rand_f();
          ad = 1'($urandom_range(0, 1));
          req_opa[32*i +: 32] = a;
          req_opb[32*i +: 32] = b;
          req_add[i]          = ad;
          pend_exp[i]         = addf(a, b, ad);
          fresh[i]            = 1'b0;
        end
        req_valid[i] = 1'b1;
      end else begin
        req_valid[i] = 1'b0;
      end
    end
    rsp_ready = want_r;
    #1;
    check_arb();
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                         input logic ad, input logic [31:0] e);
    req_opa[32*i +: 32] = a;
    req_opb[32*i +: 32] = b;
    req_add[i]          = ad;
    pend_exp[i]         = e;
    fresh[i]            = 1'b0;
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst_n     = 1'b0;
    req_valid = '0;
    rsp_ready = '0;
    m_busy    = '0;
    m_ptr     = 0;
    m_iss     = 1'b0;
    fresh     = '1;
    for (int i = 0; i < N; i++) exp_q[i].delete();
    repeat (n) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_fpu_issue", 32'(fpu_issue), 32'd0);
    check("rst_fpu_opa", fpu_opa, 32'd0);
    check("rst_fpu_opb", fpu_opb, 32'd0);
    check("rst_fpu_add", 32'(fpu_add), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    for (int i = 0; i < N; i++) check("rst_rsp_data", rsp_data[32*i +: 32], 32'd0);
  endtask

  task automatic drain();
    for (int k = 0; k < 40 && (|m_busy); k++) step('0, '1);
    for (int i = 0; i < N; i++) check("drain_outstanding", 32'(exp_q[i].size()), 32'd0);
  endtask

  // Monitor: pops the scoreboard on each response handshake, checks arrival cycle and data stability.
  initial begin : monitor
    logic [N-1:0] pv, phs;
    logic [31:0]  pd [N];
    exp_t         e;
    pv  = '0;
    phs = '0;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        pv  = '0;
        phs = '0;
        continue;
      end
      for (int i = 0; i < N; i++) begin
        if (rsp_valid[i] && (!pv[i] || phs[i])) begin
          check("rsp_expected", 32'(exp_q[i].size() != 0), 32'd1);
          if (exp_q[i].size() != 0) check("rsp_latency", cyc, exp_q[i][0].due);
        end else if (rsp_valid[i] && pv[i]) begin
          check("rsp_stable", rsp_data[32*i +: 32], pd[i]);
        end
        if (rsp_valid[i] && rsp_ready[i] && exp_q[i].size() != 0) begin
          e = exp_q[i].pop_front();
          check("rsp_data", rsp_data[32*i +: 32], e.data);
          m_busy[i] = 1'b0;
        end
        pd[i] = rsp_data[32*i +: 32];
      end
      pv  = rsp_valid;
      phs = rsp_valid & rsp_ready;
    end
  end

  initial begin : watchdog
    #(2000000);
    $display("FAIL watchdog: run did not finish, required completion within the time limit");
    $fatal(1);
  end

  initial begin : stimulus
    int base [N];
    for (int i = 0; i < N; i++) gcnt[i] = 0;
    do_reset(2);

    // Single add on requester 0: 1.0 + 2.0 = 3.0.
    set_req(0, 32'h3F80_0000, 32'h4000_0000, 1'b1, 32'h4040_0000);
    step(4'b0001, '1);
    repeat (LAT + 4) step('0, '1);

    // Subtraction to zero on requester 2.
    set_req(2, 32'h4020_0000, 32'h4020_0000, 1'b0, 32'h0000_0000);
    step(4'b0100, '1);
    repeat (LAT + 4) step('0, '1);

    // Fairness: everyone requests continuously and consumes immediately.
    for (int i = 0; i < N; i++) base[i] = gcnt[i];
    repeat (100) step('1, '1);
    for (int i = 0; i < N; i++) check("no_starve", 32'(gcnt[i] > base[i]), 32'd1);

    // Backpressure on requester 1.
    for (int i = 0; i < N; i++) base[i] = gcnt[i];
    repeat (20) step('1, 4'b1101);
    check("bp_parked", 32'(rsp_valid[1]), 32'd1);
    for (int i = 0; i < N; i++)
      if (i != 1) check("bp_others_served", 32'(gcnt[i] > base[i]), 32'd1);
    drain();

    // Random traffic.
    repeat (300) step(N'($urandom), N'($urandom));
    drain();

    // Reset with three operations in flight.
    repeat (3) step('1, '0);
    step('0, '0);
    do_reset(1);
    repeat (LAT + 6) step('0, '0);
    check("stale_dropped", 32'(rsp_valid), 32'd0);

    repeat (60) step(N'($urandom), N'($urandom));
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
